tread_ctrl_mapper: RTL and testbench
====================================

// Module: tread_ctrl_mapper
// PURPOSE
//  Converts per-player 4-way digital direction inputs (joystick/keyboard, already OR-merged) into the
//  two-lever tread signals (left fwd/bk, right fwd/bk) that tank cores expect. Sits in the emu top
//  between the input merge logic and the core's tread inputs. Generalises the fixed 2-player tread LUT to
//  N players. Adds per-bit debounce, opposite-direction (SOCD) resolution, a direct twin-lever mode and
//  selectable output polarity.
// PARAMETERS
//  NUM_PLAYERS     2    number of independent player channels (1..4)
//  DB_W            8    debounce counter width
//  DB_CYCLES       120  consecutive ce samples a raw bit must differ before it is accepted (1..2^DB_W-1)
//  SOCD_LAST_WINS  1    1: most recently pressed of an opposing pair wins; 0: opposing pair -> neutral
//  OUT_ACTIVE_LOW  1    1: tread outputs are active-low (idle = 1); 0: active-high
// PORTS
//  clk_sys     in   1              system clock
//  Reset_n     in   1              asynchronous active-low reset
//  ce          in   1              sample enable; debounce/SOCD advance only when ce=1
//  mode_i      in   1              0: joystick->tread LUT; 1: direct twin-lever
//  dir_i       in   4*NUM_PLAYERS  per player {up,down,left,right}, active-high, player p at [4p+3:4p]
//  aux_i       in   2*NUM_PLAYERS  per player {right_fw,right_bk} used only in direct mode
//  tread_o     out  4*NUM_PLAYERS  per player {l_fw,l_bk,r_fw,r_bk}, polarity per OUT_ACTIVE_LOW
//  change_o    out  NUM_PLAYERS    1-clk pulse when that player's tread_o value changes
// BEHAVIOUR
//  Reset (async assert, sync release): debounced regs, counters, last-pressed flags = 0; tread_o = all
//   idle (all 1 if OUT_ACTIVE_LOW else all 0); change_o = 0. Reset mid-debounce discards partial counts.
//  Debounce, per raw bit (dir_i and aux_i, 6 bits/player): on a ce cycle where raw != stable, cnt++;
//   when cnt reaches DB_CYCLES-1 on such a cycle, stable <= raw and cnt <= 0. On any ce cycle with
//   raw == stable, cnt <= 0. ce=0 holds everything. Hence a change held for DB_CYCLES ce samples is
//   accepted at the DB_CYCLES-th sample edge; glitches shorter than that never appear.
//  SOCD per opposing pair (up/down, left/right, right_fw/right_bk) on debounced values:
//   - only one pressed -> that one; none -> neither.
//   - both pressed, SOCD_LAST_WINS=1: the bit whose debounced rise occurred last wins; a last-pressed
//     flag updates on each debounced rise; simultaneous rises in the same cycle -> neutral.
//   - both pressed, SOCD_LAST_WINS=0 -> neutral (neither).
//  Mapping mode 0, resolved {U,D,L,R} -> {l_fw,l_bk,r_fw,r_bk}:
//   U=1100? no: U:1010  UL:0010  UR:1000  R:1001  DR:0100  D:0101  DL:0001  L:0110  neutral:0000
//   (read as l_fw,l_bk,r_fw,r_bk; U drives both fwd, R pivots l_fw+r_bk, L pivots l_bk+r_fw).
//  Mapping mode 1: l_fw=U, l_bk=D, r_fw=right_fw, r_bk=right_bk (all post-SOCD); L/R ignored.
//  mode_i is sampled every clk (not gated by ce); a mode change takes effect on the next clk edge.
//  Latency: tread_o is registered; updates 1 clk after the debounced/SOCD state changes.
//  change_o[p] = 1 for exactly the clk in which tread_o[p] takes a new value; otherwise 0.
//  Polarity inversion applied after the register; change_o is polarity-independent.
//  Players fully independent; no shared counters.
// TESTING
//  1 Reset: Reset_n=0 with dir_i=4'b1000 -> tread_o=4'b1111 (OUT_ACTIVE_LOW=1), change_o=0; hold 200 clks
//    after release with ce=1 -> tread_o for p0 = ~4'b1010 on cycle DB_CYCLES+1, change_o[0] one pulse.
//  2 Debounce: DB_CYCLES=4, ce=1, pulse right for 3 clks -> no change; hold 4 clks -> tread_o=~4'b1001.
//  3 SOCD last-wins: press up, settle, then press down -> tread_o=~4'b0101; release down -> ~4'b1010;
//    SOCD_LAST_WINS=0 with both held -> ~4'b0000 (all 1).
//  4 Full LUT: sweep all 9 resolved directions on player 1 while player 0 static -> table above on
//    tread_o[7:4], tread_o[3:0] unchanged, change_o[0] never pulses.
//  5 Direct mode: mode_i=1, dir_i={U=1}, aux_i={right_bk=1} -> {l_fw,l_bk,r_fw,r_bk}=4'b1001 next clk.
//  6 ce gating / mid-reset: ce=0 with changed input for 500 clks -> no change; assert Reset_n mid-count,
//    release -> count restarts from 0, accepted only after a further DB_CYCLES ce samples.

Source files
------------

// File: rtl/tread_ctrl_mapper.sv
// Per-player direction -> tank tread mapper: per-bit debounce, opposing-pair (SOCD)
// resolution, joystick LUT or direct twin-lever mapping, registered output with change pulse.
module tread_ctrl_mapper #(
  parameter int NUM_PLAYERS    = 2,
  parameter int DB_W           = 8,
  parameter int DB_CYCLES      = 120,
  parameter int SOCD_LAST_WINS = 1,
  parameter int OUT_ACTIVE_LOW = 1
) (
  input  logic                     clk_sys,
  input  logic                     Reset_n,
  input  logic                     ce,
  input  logic                     mode_i,
  input  logic [4*NUM_PLAYERS-1:0] dir_i,
  input  logic [2*NUM_PLAYERS-1:0] aux_i,
  output logic [4*NUM_PLAYERS-1:0] tread_o,
  output logic [NUM_PLAYERS-1:0]   change_o
);

  localparam int              NB        = 6 * NUM_PLAYERS;
  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic            LAST_WINS = (SOCD_LAST_WINS != 0);

  // Resolved {U,D,L,R} -> {l_fw,l_bk,r_fw,r_bk}; U/D and L/R are never both set here.
  function automatic logic [3:0] lut_map(input logic [3:0] udlr);
    logic [3:0] t;
    case (udlr)
      4'b1000: t = 4'b1010;
      4'b1010: t = 4'b0010;
      4'b1001: t = 4'b1000;
      4'b0001: t = 4'b1001;
      4'b0101: t = 4'b0100;
      4'b0100: t = 4'b0101;
      4'b0110: t = 4'b0001;
      4'b0010: t = 4'b0110;
      default: t = 4'b0000;
    endcase
    return t;
  endfunction

  // Player p occupies bits [6p+5:6p] = {up,down,left,right,right_fw,right_bk};
  // opposing pairs are always bits (2j+1, 2j).
  logic [NB-1:0]            raw;
  logic [NB-1:0]            stable_q, stable_d;
  logic [NB-1:0]            last_q, last_d;
  logic [NB-1:0]            rise;
  logic [NB-1:0]            res;
  logic [DB_W-1:0]          cnt_q [NB];
  logic [DB_W-1:0]          cnt_d [NB];
  logic [4*NUM_PLAYERS-1:0] tread_q, tread_d;
  logic [NUM_PLAYERS-1:0]   change_q, change_d;

  always_comb begin
    raw = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      raw[6*p +: 6] = {dir_i[4*p +: 4], aux_i[2*p +: 2]};
    end
  end

  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NB; i++) begin
      cnt_d[i] = cnt_q[i];
      if (ce) begin
        if (raw[i] != stable_q[i]) begin
          if (cnt_q[i] == DB_LAST) begin
            stable_d[i] = raw[i];
            cnt_d[i]    = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end else begin
          cnt_d[i] = '0;
        end
      end
    end
  end

  assign rise = stable_d & ~stable_q;

  // Both last flags clear after a simultaneous rise, which resolves a held pair to neutral.
  always_comb begin
    last_d = last_q;
    res    = '0;
    for (int j = 0; j < NB/2; j++) begin
      if (rise[2*j+1] | rise[2*j]) begin
        last_d[2*j+1] = rise[2*j+1] & ~rise[2*j];
        last_d[2*j]   = rise[2*j]   & ~rise[2*j+1];
      end
      res[2*j+1] = stable_q[2*j+1] &
                   (~stable_q[2*j]   | (LAST_WINS & last_q[2*j+1] & ~last_q[2*j]));
      res[2*j]   = stable_q[2*j] &
                   (~stable_q[2*j+1] | (LAST_WINS & last_q[2*j]   & ~last_q[2*j+1]));
    end
  end

  always_comb begin
    tread_d  = '0;
    change_d = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (mode_i) begin
        tread_d[4*p +: 4] = {res[6*p+5], res[6*p+4], res[6*p+1], res[6*p]};
      end else begin
        tread_d[4*p +: 4] = lut_map(res[6*p+2 +: 4]);
      end
      change_d[p] = |(tread_d[4*p +: 4] ^ tread_q[4*p +: 4]);
    end
  end

  always_ff @(posedge clk_sys or negedge Reset_n) begin
    if (!Reset_n) begin
      stable_q <= '0;
      last_q   <= '0;
      tread_q  <= '0;
      change_q <= '0;
      for (int i = 0; i < NB; i++) cnt_q[i] <= '0;
    end else begin
      stable_q <= stable_d;
      last_q   <= last_d;
      tread_q  <= tread_d;
      change_q <= change_d;
      for (int i = 0; i < NB; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Register holds active-high levels; polarity is applied only at the pins.
  assign tread_o  = (OUT_ACTIVE_LOW != 0) ? ~tread_q : tread_q;
  assign change_o = change_q;

endmodule

// File: tb/tb_tread_ctrl_mapper.sv
// Bench for tread_ctrl_mapper: expected tread changes are queued per player with their due
// cycle and compared whenever change_o pulses; a second instance covers neutral SOCD/active-high.
module tb_tread_ctrl_mapper;

  localparam int DB = 4;

  typedef struct {
    logic [3:0] val;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       Reset_n = 1'b1;
  logic       ce = 1'b1;
  logic       mode_i = 1'b0;
  logic [7:0] dir_i = 8'h08;
  logic [3:0] aux_i = 4'h0;
  logic [7:0] tread_o, tread_n;
  logic [1:0] chg, chg_n;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  exp_t q0[$];
  exp_t q1[$];

  logic [3:0] sw_in  [9] = '{4'b1000, 4'b1010, 4'b1001, 4'b0001, 4'b0101,
                             4'b0100, 4'b0110, 4'b0010, 4'b0000};
  logic [3:0] sw_out [9] = '{4'b1010, 4'b0010, 4'b1000, 4'b1001, 4'b0100,
                             4'b0101, 4'b0001, 4'b0110, 4'b0000};

  tread_ctrl_mapper #(
    .NUM_PLAYERS(2), .DB_W(8), .DB_CYCLES(DB), .SOCD_LAST_WINS(1), .OUT_ACTIVE_LOW(1)
  ) u_dut (
    .clk_sys(clk), .Reset_n(Reset_n), .ce(ce), .mode_i(mode_i),
    .dir_i(dir_i), .aux_i(aux_i), .tread_o(tread_o), .change_o(chg)
  );

  tread_ctrl_mapper #(
    .NUM_PLAYERS(2), .DB_W(8), .DB_CYCLES(DB), .SOCD_LAST_WINS(0), .OUT_ACTIVE_LOW(0)
  ) u_neu (
    .clk_sys(clk), .Reset_n(Reset_n), .ce(ce), .mode_i(mode_i),
    .dir_i(dir_i), .aux_i(aux_i), .tread_o(tread_n), .change_o(chg_n)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Queue an expected physical tread_o nibble for player p, due dly edges from now.
  task automatic expect_chg(input int p, input logic [3:0] v, input int dly);
    exp_t e;
    e.val = v;
    e.cyc = cyc + dly;
    if (p == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (Reset_n) begin
      if (chg[0]) begin
        if (q0.size() == 0) chk("p0_spurious_change", {31'b0, chg[0]}, 32'd0);
        else begin
          e = q0.pop_front();
          chk("p0_tread", {28'b0, tread_o[3:0]}, {28'b0, e.val});
          chk("p0_cycle", cyc, e.cyc);
        end
      end
      if (chg[1]) begin
        if (q1.size() == 0) chk("p1_spurious_change", {31'b0, chg[1]}, 32'd0);
        else begin
          e = q1.pop_front();
          chk("p1_tread", {28'b0, tread_o[7:4]}, {28'b0, e.val});
          chk("p1_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    // Reset with p0 holding up
    #2 Reset_n = 1'b0;
    tick(3);
    chk("rst_tread", {24'b0, tread_o}, 32'hFF);
    chk("rst_change", {30'b0, chg}, 32'd0);
    chk("rst_tread_hi", {24'b0, tread_n}, 32'h00);
    chk("rst_change_hi", {30'b0, chg_n}, 32'd0);
    Reset_n = 1'b1;
    expect_chg(0, ~4'b1010, DB + 1);
    tick(200);
    chk("neu_up", {28'b0, tread_n[3:0]}, 32'b1010);

    // Debounce: 3-sample glitch of right is ignored, then a held right is accepted
    dir_i[3:0] = 4'b1001;
    tick(3);
    dir_i[3:0] = 4'b1000;
    tick(8);
    chk("glitch_hold", {28'b0, tread_o[3:0]}, {28'b0, ~4'b1010});
    dir_i[3:0] = 4'b0001;
    expect_chg(0, ~4'b1001, DB + 1);
    tick(8);

    // SOCD
    dir_i[3:0] = 4'b0000; expect_chg(0, ~4'b0000, DB + 1); tick(8);
    dir_i[3:0] = 4'b1000; expect_chg(0, ~4'b1010, DB + 1); tick(8);
    dir_i[3:0] = 4'b1100; expect_chg(0, ~4'b0101, DB + 1); tick(8);
    chk("neu_both_ud", {28'b0, tread_n[3:0]}, 32'b0000);
    dir_i[3:0] = 4'b1000; expect_chg(0, ~4'b1010, DB + 1); tick(8);
    chk("neu_up_again", {28'b0, tread_n[3:0]}, 32'b1010);
    dir_i[3:0] = 4'b0000; expect_chg(0, ~4'b0000, DB + 1); tick(8);
    dir_i[3:0] = 4'b1100; tick(8);
    chk("simul_rise_neutral", {28'b0, tread_o[3:0]}, {28'b0, ~4'b0000});
    dir_i[3:0] = 4'b0100; expect_chg(0, ~4'b0101, DB + 1); tick(8);
    dir_i[3:0] = 4'b0110; expect_chg(0, ~4'b0001, DB + 1); tick(8);
    dir_i[3:0] = 4'b0111; expect_chg(0, ~4'b0100, DB + 1); tick(8);
    chk("neu_both_lr", {28'b0, tread_n[3:0]}, 32'b0101);

    // Full LUT sweep on player 1, player 0 static
    for (int i = 0; i < 9; i++) begin
      dir_i[7:4] = sw_in[i];
      expect_chg(1, ~sw_out[i], DB + 1);
      tick(DB + 3);
    end
    chk("p0_static", {28'b0, tread_o[3:0]}, {28'b0, ~4'b0100});

    // Direct twin-lever mode
    dir_i[3:0] = 4'b1000;
    aux_i[1:0] = 2'b01;
    expect_chg(0, ~4'b1010, DB + 1);
    tick(8);
    mode_i = 1'b1; expect_chg(0, ~4'b1001, 1); tick(3);
    chk("neu_direct", {28'b0, tread_n[3:0]}, 32'b1001);
    mode_i = 1'b0; expect_chg(0, ~4'b1010, 1); tick(3);

    // ce gating, then reset in the middle of a count
    ce = 1'b0;
    dir_i[3:0] = 4'b0001;
    aux_i[1:0] = 2'b00;
    tick(500);
    chk("ce_hold", {24'b0, tread_o}, {24'b0, ~4'b0000, ~4'b1010});
    ce = 1'b1;
    tick(2);
    Reset_n = 1'b0;
    tick(2);
    chk("midrst_tread", {24'b0, tread_o}, 32'hFF);
    chk("midrst_change", {30'b0, chg}, 32'd0);
    Reset_n = 1'b1;
    expect_chg(0, ~4'b1001, DB + 1);
    tick(10);

    // Intermittent ce: four samples spread over alternate clocks
    dir_i[3:0] = 4'b0000;
    expect_chg(0, ~4'b0000, 2 * DB);
    for (int i = 0; i < 10; i++) begin
      ce = (i % 2 == 0);
      tick(1);
    end
    ce = 1'b1;
    tick(10);

    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
